spike_counter_array: RTL and testbench

- Parametrised successor to the single-channel async spike counter.
- Counts raw spikes on NCH independent channels (neuron each_spike lines or FPGA-FPGA spikein pins) in the fast clock domain.
- Snapshots and clears all channels together on each simulation-window tick (sim_clk), so host/okWireOut readout sees per-window spike counts.
- Adds per-channel saturation flags, a window sequence number and selectable readout.

---
 rtl/spike_cnt_pkg.sv | 29 ++
 rtl/spike_sync_edge.sv | 30 +++
 rtl/spike_counter_array.sv | 139 +++++++++++++
 tb/tb_spike_counter_array.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_cnt_pkg.sv
// Shared defaults, widths and the saturating-increment helper for the
// spike counter array and its synchroniser.
`timescale 1ns/1ps
package spike_cnt_pkg;

   localparam int DEFAULT_NCH         = 14;
   localparam int DEFAULT_CNT_W       = 32;
   localparam int DEFAULT_SYNC_STAGES = 2;
   localparam int DEFAULT_SEL_W       = 4;
   localparam int WINDOW_ID_W         = 16;
   localparam int MAX_CNT_W           = 64;

   typedef logic [WINDOW_ID_W-1:0] window_id_t;

   // Counters up to MAX_CNT_W bits share this helper; the caller narrows the result.
   function automatic logic [MAX_CNT_W-1:0] sat_inc(
      input logic [MAX_CNT_W-1:0] value,
      input logic                 inc,
      input int                   width
   );
      logic [MAX_CNT_W-1:0] ceiling;
      ceiling = (width >= MAX_CNT_W) ? '1 : ((64'd1 << width) - 64'd1);
      if (inc && (value < ceiling))
         sat_inc = value + 64'd1;
      else
         sat_inc = value;
   endfunction

endpackage

// File: rtl/spike_sync_edge.sv
// Multi-flop synchroniser followed by a rising-edge detector; the rise output
// is a one-clock strobe per 0->1 transition of the asynchronous input.
`timescale 1ns/1ps
module spike_sync_edge
   import spike_cnt_pkg::*;
#(
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic clk,
   input  logic reset_global,
   input  logic async_in,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or posedge reset_global) begin
      if (reset_global) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/spike_counter_array.sv
// NCH-channel windowed spike counter: live counts are snapshotted and cleared on
// every window_tick rising edge. Define SPIKE_CNT_TOTAL_EN for cumulative totals.
`timescale 1ns/1ps
module spike_counter_array
   import spike_cnt_pkg::*;
#(
   parameter int NCH         = DEFAULT_NCH,
   parameter int CNT_W       = DEFAULT_CNT_W,
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
   parameter int SEL_W       = DEFAULT_SEL_W
) (
   input  logic                   clk,
   input  logic                   reset_global,
   input  logic [NCH-1:0]         spike_in,
   input  logic                   window_tick,
   input  logic [SEL_W-1:0]       sel,
   output logic [CNT_W-1:0]       cnt_out,
   output logic                   cnt_valid,
   output logic [WINDOW_ID_W-1:0] window_id,
   output logic [NCH-1:0]         sat_flags,
   output logic [CNT_W-1:0]       total_out
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NCH-1:0]   spike_rise;
   logic             tick;
   logic [CNT_W-1:0] held_bus [NCH];
   logic [CNT_W-1:0] held_sel;

   spike_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
      .clk          (clk),
      .reset_global (reset_global),
      .async_in     (window_tick),
      .rise         (tick)
   );

   generate
      for (genvar i = 0; i < NCH; i++) begin : g_ch
         logic [CNT_W-1:0] live_q;
         logic [CNT_W-1:0] held_q;
         logic [CNT_W-1:0] live_next;
         logic             live_sat_q;
         logic             sat_q;

         spike_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_spike_sync (
            .clk          (clk),
            .reset_global (reset_global),
            .async_in     (spike_in[i]),
            .rise         (spike_rise[i])
         );

         assign live_next = CNT_W'(sat_inc(MAX_CNT_W'(live_q), spike_rise[i], CNT_W));

         // A spike landing on the tick cycle belongs to the window being closed.
         always_ff @(posedge clk or posedge reset_global) begin
            if (reset_global) begin
               live_q     <= '0;
               held_q     <= '0;
               live_sat_q <= 1'b0;
               sat_q      <= 1'b0;
            end else if (tick) begin
               held_q     <= live_next;
               live_q     <= '0;
               sat_q      <= live_sat_q | (live_next == CNT_MAX);
               live_sat_q <= 1'b0;
            end else begin
               live_q <= live_next;
               if (live_next == CNT_MAX)
                  live_sat_q <= 1'b1;
            end
         end

         assign held_bus[i]  = held_q;
         assign sat_flags[i] = sat_q;
      end
   endgenerate

   // Out-of-range selects fall through to zero.
   always_comb begin
      held_sel = '0;
      for (int k = 0; k < NCH; k++) begin
         if (sel == SEL_W'(k))
            held_sel = held_bus[k];
      end
   end

   always_ff @(posedge clk or posedge reset_global) begin
      if (reset_global) begin
         cnt_out   <= '0;
         cnt_valid <= 1'b0;
         window_id <= '0;
      end else begin
         cnt_out   <= held_sel;
         cnt_valid <= tick;
         if (tick)
            window_id <= window_id + 1'b1;
      end
   end

`ifdef SPIKE_CNT_TOTAL_EN
   logic [CNT_W-1:0] total_bus [NCH];
   logic [CNT_W-1:0] total_sel;

   generate
      for (genvar i = 0; i < NCH; i++) begin : g_total
         logic [CNT_W-1:0] total_q;

         // Cumulative count ignores window boundaries entirely.
         always_ff @(posedge clk or posedge reset_global) begin
            if (reset_global)
               total_q <= '0;
            else
               total_q <= CNT_W'(sat_inc(MAX_CNT_W'(total_q), spike_rise[i], CNT_W));
         end

         assign total_bus[i] = total_q;
      end
   endgenerate

   always_comb begin
      total_sel = '0;
      for (int k = 0; k < NCH; k++) begin
         if (sel == SEL_W'(k))
            total_sel = total_bus[k];
      end
   end

   always_ff @(posedge clk or posedge reset_global) begin
      if (reset_global)
         total_out <= '0;
      else
         total_out <= total_sel;
   end
`else
   assign total_out = '0;
`endif

endmodule

// File: tb/tb_spike_counter_array.sv
// Bench for spike_counter_array: a 32-bit and a 4-bit counter instance share the
// same stimulus and are compared against a per-window counting model.
`timescale 1ns/1ps
module tb_spike_counter_array;

   localparam int NCH     = 14;
   localparam int SEL_W   = 4;
   localparam int BIG_W   = 32;
   localparam int SMALL_W = 4;
   localparam longint unsigned BIG_MAX   = 64'hFFFF_FFFF;
   localparam longint unsigned SMALL_MAX = 64'd15;

   logic               clk          = 1'b0;
   logic               reset_global = 1'b0;
   logic [NCH-1:0]     spike_in     = '0;
   logic               window_tick  = 1'b0;
   logic [SEL_W-1:0]   sel          = '0;

   logic [BIG_W-1:0]   cnt_out_big,   total_out_big;
   logic [SMALL_W-1:0] cnt_out_small, total_out_small;
   logic               cnt_valid_big, cnt_valid_small;
   logic [15:0]        window_id_big, window_id_small;
   logic [NCH-1:0]     sat_flags_big, sat_flags_small;

   int vectors     = 0;
   int miscompares = 0;

   longint unsigned live_cnt [NCH];
   longint unsigned held_cnt [NCH];
   longint unsigned tot_cnt  [NCH];
   int              win_id;

   spike_counter_array #(.NCH(NCH), .CNT_W(BIG_W), .SYNC_STAGES(2), .SEL_W(SEL_W)) dut (
      .clk          (clk),
      .reset_global (reset_global),
      .spike_in     (spike_in),
      .window_tick  (window_tick),
      .sel          (sel),
      .cnt_out      (cnt_out_big),
      .cnt_valid    (cnt_valid_big),
      .window_id    (window_id_big),
      .sat_flags    (sat_flags_big),
      .total_out    (total_out_big)
   );

   spike_counter_array #(.NCH(NCH), .CNT_W(SMALL_W), .SYNC_STAGES(2), .SEL_W(SEL_W)) dut_small (
      .clk          (clk),
      .reset_global (reset_global),
      .spike_in     (spike_in),
      .window_tick  (window_tick),
      .sel          (sel),
      .cnt_out      (cnt_out_small),
      .cnt_valid    (cnt_valid_small),
      .window_id    (window_id_small),
      .sat_flags    (sat_flags_small),
      .total_out    (total_out_small)
   );

   always #5 clk = ~clk;

   function automatic longint unsigned cap(input longint unsigned v, input longint unsigned m);
      return (v > m) ? m : v;
   endfunction

   function automatic void model_reset();
      for (int ch = 0; ch < NCH; ch++) begin
         live_cnt[ch] = 0;
         held_cnt[ch] = 0;
         tot_cnt[ch]  = 0;
      end
      win_id = 0;
   endfunction

   function automatic void model_pulse(input logic [NCH-1:0] mask);
      for (int ch = 0; ch < NCH; ch++) begin
         if (mask[ch]) begin
            live_cnt[ch]++;
            tot_cnt[ch]++;
         end
      end
   endfunction

   function automatic void model_close();
      for (int ch = 0; ch < NCH; ch++) begin
         held_cnt[ch] = live_cnt[ch];
         live_cnt[ch] = 0;
      end
      win_id = (win_id + 1) % 65536;
   endfunction

   function automatic logic [NCH-1:0] exp_sat(input longint unsigned m);
      logic [NCH-1:0] v;
      for (int ch = 0; ch < NCH; ch++)
         v[ch] = (held_cnt[ch] >= m);
      return v;
   endfunction

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic apply_reset();
      reset_global = 1'b1;
      spike_in     = '0;
      window_tick  = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_output("reset cnt_out32",   64'(cnt_out_big),   64'd0);
      check_output("reset cnt_out4",    64'(cnt_out_small), 64'd0);
      check_output("reset cnt_valid",   64'(cnt_valid_big), 64'd0);
      check_output("reset window_id",   64'(window_id_big), 64'd0);
      check_output("reset sat_flags4",  64'(sat_flags_small), 64'd0);
      check_output("reset total_out32", 64'(total_out_big), 64'd0);
      reset_global = 1'b0;
      @(negedge clk);
   endtask

   task automatic apply_pulses(input logic [NCH-1:0] mask, input int n);
      for (int p = 0; p < n; p++) begin
         spike_in = mask;
         model_pulse(mask);
         repeat (2) @(negedge clk);
         spike_in = '0;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic check_readout(input int ch);
      longint unsigned e_big, e_small, e_tbig, e_tsmall;
      e_big = 0; e_small = 0; e_tbig = 0; e_tsmall = 0;
      sel = SEL_W'(ch);
      @(negedge clk);
      if (ch < NCH) begin
         e_big    = cap(held_cnt[ch], BIG_MAX);
         e_small  = cap(held_cnt[ch], SMALL_MAX);
         e_tbig   = cap(tot_cnt[ch], BIG_MAX);
         e_tsmall = cap(tot_cnt[ch], SMALL_MAX);
      end
`ifndef SPIKE_CNT_TOTAL_EN
      e_tbig   = 0;
      e_tsmall = 0;
`endif
      check_output($sformatf("cnt_out32 sel=%0d", ch),   64'(cnt_out_big),     e_big);
      check_output($sformatf("cnt_out4 sel=%0d", ch),    64'(cnt_out_small),   e_small);
      check_output($sformatf("total_out32 sel=%0d", ch), 64'(total_out_big),   e_tbig);
      check_output($sformatf("total_out4 sel=%0d", ch),  64'(total_out_small), e_tsmall);
   endtask

   task automatic check_all_channels();
      for (int ch = 0; ch < (1 << SEL_W); ch++)
         check_readout(ch);
   endtask

   // Raise window_tick (optionally with a simultaneous spike mask) and follow the snapshot.
   task automatic apply_tick(input logic [NCH-1:0] mask);
      bit seen;
      seen = 1'b0;
      model_pulse(mask);
      model_close();
      spike_in    = mask;
      window_tick = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i == 1) begin
            spike_in    = '0;
            window_tick = 1'b0;
         end
         if (cnt_valid_big) begin
            seen = 1'b1;
            break;
         end
      end
      spike_in    = '0;
      window_tick = 1'b0;
      check_output("cnt_valid pulse seen", 64'(seen), 64'd1);
      check_output("cnt_valid4 with 32",   64'(cnt_valid_small), 64'(cnt_valid_big));
      check_output("window_id32",  64'(window_id_big),   64'(win_id));
      check_output("window_id4",   64'(window_id_small), 64'(win_id));
      check_output("sat_flags32",  64'(sat_flags_big),   64'(exp_sat(BIG_MAX)));
      check_output("sat_flags4",   64'(sat_flags_small), 64'(exp_sat(SMALL_MAX)));
      @(negedge clk);
      check_output("cnt_valid one cycle", 64'(cnt_valid_big), 64'd0);
      check_all_channels();
   endtask

   task automatic apply_double_tick();
      int valid_seen;
      valid_seen = 0;
      model_close();
      model_close();
      for (int i = 0; i < 16; i++) begin
         window_tick = (i == 0 || i == 2);
         @(negedge clk);
         if (cnt_valid_big)
            valid_seen++;
      end
      check_output("back-to-back valid count", 64'(valid_seen), 64'd2);
      check_output("back-to-back window_id",   64'(window_id_big), 64'(win_id));
      check_readout(5);
      check_readout(0);
   endtask

   initial begin
      logic [NCH-1:0] mask;

      $display("[TB] start");
      apply_reset();

      // Basic per-channel counting.
      apply_pulses(NCH'(1) << 0, 5);
      apply_pulses(NCH'(1) << 13, 3);
      apply_tick('0);

      // A held-high level counts once; then an empty window.
      spike_in[2] = 1'b1;
      model_pulse(NCH'(1) << 2);
      repeat (100) @(negedge clk);
      spike_in = '0;
      repeat (2) @(negedge clk);
      apply_tick('0);
      apply_tick('0);

      // Spike edge coincident with the tick edge joins the closing window.
      apply_pulses(NCH'(1) << 4, 7);
      apply_tick(NCH'(1) << 4);
      apply_tick('0);

      // Saturation on the 4-bit instance, then recovery.
      apply_pulses(NCH'(1) << 1, 20);
      apply_tick('0);
      apply_pulses(NCH'(1) << 1, 3);
      apply_tick('0);

      // Two closely spaced ticks; the second window is empty.
      apply_pulses(NCH'(1) << 5, 3);
      apply_double_tick();

      // Reset in the middle of a window.
      apply_pulses(NCH'(1) << 0, 9);
      apply_reset();
      apply_pulses(NCH'(1) << 0, 2);
      apply_tick('0);

      // Cumulative totals across windows.
      apply_reset();
      apply_pulses(NCH'(1) << 3, 4);
      apply_tick('0);
      apply_pulses(NCH'(1) << 3, 6);
      apply_tick('0);
      apply_pulses(NCH'(1) << 3, 5);
      apply_tick('0);

      // Randomised windows with all channels active.
      for (int w = 0; w < 8; w++) begin
         int n;
         n = int'($urandom_range(0, 6));
         for (int p = 0; p < n; p++) begin
            mask = NCH'($urandom);
            apply_pulses(mask, 1);
         end
         mask = ($urandom_range(0, 1) == 1) ? NCH'($urandom) : '0;
         apply_tick(mask);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
